// File: rtl/arb_calibration_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : arb_calibration_ctrl
// Brief    : Repeated-race calibration of an arbiter bank; majority response
//            plus reliability flag per channel.
// Revision : 1.0
// ============================================================================
module arb_calibration_ctrl #(
    parameter int CHANNELS = 4,
    parameter int REPEAT   = 16,
    parameter int SETTLE   = 4,
    parameter int THRESH   = 2,
    parameter int CNT_W    = $clog2(REPEAT + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [CHANNELS-1:0]       arb_q,
    input  logic [CHANNELS-1:0]       arb_stable,
    output logic                      arb_rst,
    output logic                      launch,
    output logic                      busy,
    output logic                      done,
    output logic [CHANNELS-1:0]       resp,
    output logic [CHANNELS-1:0]       reliable,
    output logic [CHANNELS*CNT_W-1:0] ones_cnt,
    output logic [CHANNELS*CNT_W-1:0] meta_cnt
);

    localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0]  c_REP_LAST  = CNT_W'(REPEAT - 1);
    localparam logic [CNT_W-1:0]  c_HALF      = CNT_W'(REPEAT / 2);
    localparam logic [CNT_W-1:0]  c_HI        = CNT_W'(REPEAT - THRESH);
    localparam logic [CNT_W-1:0]  c_LO        = CNT_W'(THRESH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_SAMPLE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    rep_q, rep_d;
    logic [CNT_W-1:0]    ones_q [CHANNELS];
    logic [CNT_W-1:0]    ones_d [CHANNELS];
    logic [CNT_W-1:0]    meta_q [CHANNELS];
    logic [CNT_W-1:0]    meta_d [CHANNELS];
    logic [CNT_W-1:0]    res_ones_q [CHANNELS];
    logic [CNT_W-1:0]    res_ones_d [CHANNELS];
    logic [CNT_W-1:0]    res_meta_q [CHANNELS];
    logic [CNT_W-1:0]    res_meta_d [CHANNELS];
    logic [CHANNELS-1:0] resp_q, resp_d;
    logic [CHANNELS-1:0] rel_q, rel_d;
    logic                arb_rst_q, arb_rst_d;
    logic                launch_q, launch_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                w_enter_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_CLEAR;
            S_CLEAR:  state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT:   if (wait_q == c_WAIT_LAST) state_d = S_SAMPLE;
            S_SAMPLE: state_d = (rep_q == c_REP_LAST) ? S_DONE : S_CLEAR;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // Abort overrides every transition, including the one into DONE.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    assign w_enter_done = (state_q == S_SAMPLE) && (state_d == S_DONE);

    always_comb begin
        wait_d = (state_q == S_WAIT) ? wait_q + WAIT_W'(1) : '0;

        rep_d = rep_q;
        if (state_q == S_IDLE) begin
            rep_d = '0;
        end else if ((state_q == S_SAMPLE) && (state_d == S_CLEAR)) begin
            rep_d = rep_q + CNT_W'(1);
        end

        resp_d = resp_q;
        rel_d  = rel_q;
        for (int i = 0; i < CHANNELS; i++) begin
            ones_d[i]     = ones_q[i];
            meta_d[i]     = meta_q[i];
            res_ones_d[i] = res_ones_q[i];
            res_meta_d[i] = res_meta_q[i];

            if (state_q == S_IDLE) begin
                ones_d[i] = '0;
                meta_d[i] = '0;
            end else if ((state_q == S_SAMPLE) && !abort) begin
                if (arb_stable[i]) begin
                    ones_d[i] = ones_q[i] + CNT_W'(arb_q[i]);
                end else begin
                    meta_d[i] = meta_q[i] + CNT_W'(1);
                end
            end

            // Results are taken from the post-sample values of the last run.
            if (w_enter_done) begin
                res_ones_d[i] = ones_d[i];
                res_meta_d[i] = meta_d[i];
                resp_d[i]     = (ones_d[i] > c_HALF);
                rel_d[i]      = (meta_d[i] == '0) &&
                                ((ones_d[i] >= c_HI) || (ones_d[i] <= c_LO));
            end
        end

        arb_rst_d = (state_d == S_IDLE) || (state_d == S_CLEAR) || (state_d == S_DONE);
        launch_d  = (state_d == S_LAUNCH);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q    <= '0;
            rep_q     <= '0;
            resp_q    <= '0;
            rel_q     <= '0;
            arb_rst_q <= 1'b1;
            launch_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                ones_q[i]     <= '0;
                meta_q[i]     <= '0;
                res_ones_q[i] <= '0;
                res_meta_q[i] <= '0;
            end
        end else begin
            wait_q    <= wait_d;
            rep_q     <= rep_d;
            resp_q    <= resp_d;
            rel_q     <= rel_d;
            arb_rst_q <= arb_rst_d;
            launch_q  <= launch_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            for (int i = 0; i < CHANNELS; i++) begin
                ones_q[i]     <= ones_d[i];
                meta_q[i]     <= meta_d[i];
                res_ones_q[i] <= res_ones_d[i];
                res_meta_q[i] <= res_meta_d[i];
            end
        end
    end

    assign arb_rst  = arb_rst_q;
    assign launch   = launch_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign resp     = resp_q;
    assign reliable = rel_q;

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
            assign ones_cnt[g*CNT_W +: CNT_W] = res_ones_q[g];
            assign meta_cnt[g*CNT_W +: CNT_W] = res_meta_q[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_arb_calibration_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb_calibration_ctrl
// Brief    : Randomised bench for arb_calibration_ctrl with a counting model.
// Revision : 1.0
// ============================================================================
module tb_arb_calibration_ctrl;

    localparam int CH   = 4;
    localparam int REP  = 16;
    localparam int SET  = 4;
    localparam int THR  = 2;
    localparam int CW   = $clog2(REP + 1);
    localparam int EVAL = SET + 3;
    localparam int RUN  = REP * EVAL;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [CH-1:0]    arb_q;
    logic [CH-1:0]    arb_stable;
    logic             arb_rst;
    logic             launch;
    logic             busy;
    logic             done;
    logic [CH-1:0]    resp;
    logic [CH-1:0]    reliable;
    logic [CH*CW-1:0] ones_cnt;
    logic [CH*CW-1:0] meta_cnt;

    arb_calibration_ctrl #(
        .CHANNELS (CH),
        .REPEAT   (REP),
        .SETTLE   (SET),
        .THRESH   (THR)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .arb_q      (arb_q),
        .arb_stable (arb_stable),
        .arb_rst    (arb_rst),
        .launch     (launch),
        .busy       (busy),
        .done       (done),
        .resp       (resp),
        .reliable   (reliable),
        .ones_cnt   (ones_cnt),
        .meta_cnt   (meta_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [CH-1:0]    pat_q [REP];
    logic [CH-1:0]    pat_s [REP];
    logic [CH*CW-1:0] exp_ones;
    logic [CH*CW-1:0] exp_meta;
    logic [CH-1:0]    exp_resp;
    logic [CH-1:0]    exp_rel;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Count ones among stable samples and unstable samples per channel.
    task automatic compute_model();
        int ones;
        int meta;
        for (int c = 0; c < CH; c++) begin
            ones = 0;
            meta = 0;
            for (int k = 0; k < REP; k++) begin
                if (pat_s[k][c]) ones += int'(pat_q[k][c]);
                else             meta += 1;
            end
            exp_ones[c*CW +: CW] = CW'(ones);
            exp_meta[c*CW +: CW] = CW'(meta);
            exp_resp[c]          = (ones > REP / 2);
            exp_rel[c]           = (meta == 0) && ((ones >= REP - THR) || (ones <= THR));
        end
    endtask

    task automatic gen_random();
        int biases [5];
        int bias [CH];
        biases = '{0, 5, 50, 95, 100};
        for (int c = 0; c < CH; c++) bias[c] = biases[$urandom_range(0, 4)];
        for (int k = 0; k < REP; k++) begin
            for (int c = 0; c < CH; c++) begin
                pat_q[k][c] = ($urandom_range(0, 99) < bias[c]);
                pat_s[k][c] = ($urandom_range(0, 99) >= 4);
            end
        end
    endtask

    task automatic check_results(input string tag);
        check_eq({tag, "_ones"}, 64'(ones_cnt), 64'(exp_ones));
        check_eq({tag, "_meta"}, 64'(meta_cnt), 64'(exp_meta));
        check_eq({tag, "_resp"}, 64'(resp), 64'(exp_resp));
        check_eq({tag, "_rel"},  64'(reliable), 64'(exp_rel));
    endtask

    // mode 0: start pulse; 1: start held through DONE; 2: extra start pulse mid-run.
    // abort_e >= 0 asserts abort for the edge following edge abort_e.
    task automatic run(input string tag, input int mode, input int abort_e);
        int  k;
        int  n_done;
        int  e_done;
        int  e_first;
        int  bad_busy;
        int  last;
        bit  exp_busy;
        k        = 0;
        n_done   = 0;
        e_done   = -1;
        e_first  = -1;
        bad_busy = 0;
        last     = (abort_e >= 0) ? abort_e + 3 : RUN + 2;
        @(negedge clk);
        start = 1'b1;
        for (int e = 0; e <= last; e++) begin
            @(negedge clk);
            exp_busy = (abort_e >= 0) ? (e <= abort_e) : (e <= RUN);
            if (busy !== exp_busy) bad_busy++;
            if (done === 1'b1) begin
                n_done++;
                e_done = e;
            end
            if (launch === 1'b1) begin
                if (e_first < 0) e_first = e;
                if (k < REP) begin
                    arb_q      = pat_q[k];
                    arb_stable = pat_s[k];
                end
                k++;
            end
            start = ((mode == 1) && (e <= RUN)) || ((mode == 2) && (e == 50));
            abort = (e == abort_e);
        end
        start = 1'b0;
        abort = 1'b0;
        check_eq({tag, "_busy_profile"}, 64'(bad_busy), 64'd0);
        check_eq({tag, "_first_launch"}, 64'(e_first), 64'd1);
        if (abort_e >= 0) begin
            check_eq({tag, "_launches"}, 64'(k), 64'((abort_e - 1) / EVAL + 1));
            check_eq({tag, "_no_done"}, 64'(n_done), 64'd0);
        end else begin
            check_eq({tag, "_launches"}, 64'(k), 64'(REP));
            check_eq({tag, "_done_count"}, 64'(n_done), 64'd1);
            check_eq({tag, "_done_edge"}, 64'(e_done), 64'(RUN));
            compute_model();
        end
        check_results(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_arb_rst"}, 64'(arb_rst), 64'd1);
        check_eq({tag, "_launch"},  64'(launch), 64'd0);
        check_eq({tag, "_busy"},    64'(busy), 64'd0);
        check_eq({tag, "_done"},    64'(done), 64'd0);
        exp_ones = '0;
        exp_meta = '0;
        exp_resp = '0;
        exp_rel  = '0;
        check_results(tag);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        arb_q      = '0;
        arb_stable = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_arb_rst", 64'(arb_rst), 64'd1);

        for (int k = 0; k < REP; k++) begin
            pat_q[k] = 4'b0101;
            pat_s[k] = 4'hF;
        end
        run("const", 0, -1);

        for (int k = 0; k < REP; k++) begin
            pat_q[k]    = 4'b1010;
            pat_q[k][0] = k[0];
            pat_s[k]    = 4'hF;
        end
        run("toggle", 0, -1);

        for (int k = 0; k < REP; k++) begin
            pat_q[k] = 4'b0010;
            pat_s[k] = 4'hF;
        end
        pat_s[2][1] = 1'b0;
        pat_s[8][1] = 1'b0;
        run("meta", 0, -1);

        gen_random();
        run("abort", 0, 6 * EVAL + 3);
        run("after_abort", 0, -1);

        for (int r = 0; r < 4; r++) begin
            gen_random();
            run($sformatf("rand%0d", r), 0, -1);
        end

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_launch", 64'(launch), 64'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrun_rst");
        @(negedge clk);
        rst = 1'b0;
        gen_random();
        run("post_rst", 0, -1);

        gen_random();
        run("hold_start", 1, -1);
        gen_random();
        run("busy_start", 2, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
